// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the wait-state counter width.
package dmem_responder_pkg;

    // Access size encodings carried on req_bhw
    localparam logic [1:0] BHW_WORD = 2'b00;
    localparam logic [1:0] BHW_HALF = 2'b01;
    localparam logic [1:0] BHW_BYTE = 2'b10;
    localparam logic [1:0] BHW_RSVD = 2'b11;

    // Wait-state counter width (WAIT_CYCLES range 0..15)
    localparam int CNT_W = 4;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_responder_lane.sv
// Combinational lane unit: picks the addressed byte lanes out of a memory
// word for loads (with sign/zero extension), merges store data into the old
// word, and flags misaligned or reserved-size accesses.
module dmem_responder_lane
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  bhw_i,
    input  logic        sgn_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o,
    output logic        misalign_o
);

    logic [3:0]  lane_en;
    logic [31:0] wdata_rep;
    logic [31:0] shifted;

    assign shifted = word_i >> {addr_lo_i, 3'b000};

    // Lane enables, store-data replication and alignment check per size
    always_comb begin
        lane_en    = 4'b0000;
        wdata_rep  = wdata_i;
        misalign_o = 1'b1;
        case (bhw_i)
            BHW_WORD: begin
                lane_en    = 4'b1111;
                wdata_rep  = wdata_i;
                misalign_o = (addr_lo_i != 2'b00);
            end
            BHW_HALF: begin
                lane_en    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {wdata_i[15:0], wdata_i[15:0]};
                misalign_o = addr_lo_i[0];
            end
            BHW_BYTE: begin
                lane_en    = 4'b0001 << addr_lo_i;
                wdata_rep  = {4{wdata_i[7:0]}};
                misalign_o = 1'b0;
            end
            default: begin
                lane_en    = 4'b0000;
                wdata_rep  = wdata_i;
                misalign_o = 1'b1;
            end
        endcase
    end

    // Only enabled lanes take new data; the rest keep the old word
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign store_word_o[8*gi +: 8] = lane_en[gi] ? wdata_rep[8*gi +: 8]
                                                         : word_i[8*gi +: 8];
        end
    endgenerate

    // Right-justify the addressed lane(s) and extend to 32 bits
    always_comb begin
        load_data_o = word_i;
        case (bhw_i)
            BHW_HALF: load_data_o = {{16{sgn_i & shifted[15]}}, shifted[15:0]};
            BHW_BYTE: load_data_o = {{24{sgn_i & shifted[7]}},  shifted[7:0]};
            default:  load_data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store per handshake, waits
// WAIT_CYCLES, performs the lane access on its word array and holds the
// response until the CPU takes it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_bhw_i,
    input  logic              req_sgn_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       rd_word_q;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q, sgn_q;
    logic [1:0]        bhw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              accept, access, mem_we;
    logic [31:0]       load_data, store_word;
    logic              misalign;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: IDLE -> WAIT -> RESP -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid_i)    state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == '0)    state_d = ST_RESP;
            ST_RESP: if (rsp_ready_i)    state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; ready is held low for the whole time reset is asserted
    always_comb begin
        req_ready_o = (state_q == ST_IDLE) && rst_ni;
        rsp_valid_o = (state_q == ST_RESP);
        accept      = req_valid_i && req_ready_o;
        access      = (state_q == ST_WAIT) && (cnt_q == '0);
    end

    // Request latch, wait counter and held response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            bhw_q   <= BHW_WORD;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q   <= CNT_W'(WAIT_CYCLES);
                we_q    <= req_we_i;
                sgn_q   <= req_sgn_i;
                bhw_q   <= req_bhw_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end else if (state_q == ST_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (access) begin
                err_q   <= misalign;
                rdata_q <= (misalign || we_q) ? 32'h0 : load_data;
            end
        end
    end

    // The word is read when the request is accepted; nothing else writes the
    // array between accept and access, so the registered copy is still current
    // at the read-modify-write edge.
    assign mem_we = access && we_q && !misalign;

    // Word array: registered read at accept, merged write at access
    always_ff @(posedge clk_i) begin
        if (accept) rd_word_q <= mem_q[req_addr_i[ADDR_W-1:2]];
        if (mem_we) mem_q[addr_q[ADDR_W-1:2]] <= store_word;
    end

    dmem_responder_lane u_lane (
        .bhw_i        (bhw_q),
        .sgn_i        (sgn_q),
        .addr_lo_i    (addr_q[1:0]),
        .word_i       (rd_word_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (store_word),
        .misalign_o   (misalign)
    );

    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: two instances (0 and 3 wait states) checked
// against a byte-addressed reference model with directed and random traffic.
module tb_dmem_responder;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid, req_ready, req_we, req_sgn;
    logic [1:0]       rsp_valid, rsp_ready, rsp_err;
    logic [1:0][1:0]  req_bhw;
    logic [1:0][11:0] req_addr;
    logic [1:0][31:0] req_wdata, rsp_rdata;

    int checks = 0;
    int errors = 0;

    // Reference memory: 64 bytes per instance, little-endian
    logic [7:0] bm [2][64];

    dmem_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_we_i(req_we[0]), .req_bhw_i(req_bhw[0]), .req_sgn_i(req_sgn[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
    );

    dmem_responder #(.ADDR_W(12), .WAIT_CYCLES(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_we_i(req_we[1]), .req_bhw_i(req_bhw[1]), .req_sgn_i(req_sgn[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int wait_of(input int sel);
        return (sel == 0) ? 0 : 3;
    endfunction

    // Reference access: size from bhw, alignment by modulo, byte-wise update/extract
    function automatic void model_op(input int sel, input logic we, input logic [1:0] bhw,
                                     input logic sgn, input logic [11:0] addr,
                                     input logic [31:0] wdata,
                                     output logic [31:0] rdata, output logic err);
        int size;
        int a;
        logic [31:0] v;
        a = int'(addr);
        case (bhw)
            2'b00:   size = 4;
            2'b01:   size = 2;
            2'b10:   size = 1;
            default: size = 0;
        endcase
        rdata = 32'h0;
        if (size == 0) err = 1'b1;
        else           err = ((a % size) != 0);
        if (err) return;
        if (we) begin
            for (int i = 0; i < size; i++) bm[sel][a + i] = wdata[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(bm[sel][a + i]) << (8 * i));
            if (sgn && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
            rdata = v;
        end
    endfunction

    // Drive one transaction, measure edges from accept to rsp_valid, then
    // hold rsp_ready low for 'hold' cycles before taking the response.
    task automatic run_txn(input int sel, input logic we, input logic [1:0] bhw,
                           input logic sgn, input logic [11:0] addr, input logic [31:0] wdata,
                           input int hold,
                           output logic [31:0] obs_rdata, output logic obs_err, output int lat,
                           output logic [31:0] exp_rdata, output logic exp_err);
        int n;
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        obs_rdata = 32'hx;
        obs_err   = 1'bx;
        lat       = -1;
        @(negedge clk);
        req_we[sel]    = we;
        req_bhw[sel]   = bhw;
        req_sgn[sel]   = sgn;
        req_addr[sel]  = addr;
        req_wdata[sel] = wdata;
        req_valid[sel] = 1'b1;
        rsp_ready[sel] = 1'b0;
        n = 0;
        while (req_ready[sel] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            req_valid[sel] = 1'b0;
            return;
        end
        model_op(sel, we, bhw, sgn, addr, wdata, exp_rdata, exp_err);
        @(posedge clk);
        #1 req_valid[sel] = 1'b0;
        n = 0;
        @(negedge clk);
        while (rsp_valid[sel] !== 1'b1 && n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (n >= 50) return;
        lat       = n;
        obs_rdata = rsp_rdata[sel];
        obs_err   = rsp_err[sel];
        $display("txn inst%0d we=%0d bhw=%0d sgn=%0d addr=%03h wdata=%08h -> rdata=%08h err=%0d lat=%0d",
                 sel, we, bhw, sgn, addr, wdata, obs_rdata, obs_err, lat);
        repeat (hold) @(negedge clk);
        rsp_ready[sel] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[sel] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_sgn   = '0;
        rsp_ready = '0;
        req_bhw   = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (req_ready[s] !== 1'b0 || rsp_valid[s] !== 1'b0 ||
                rsp_rdata[s] !== 32'h0 || rsp_err[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_values inst%0d got ready=%b valid=%b rdata=%h err=%b expected 0/0/0/0",
                         s, req_ready[s], rsp_valid[s], rsp_rdata[s], rsp_err[s]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (req_ready[s] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release_ready inst%0d got %b expected 1", s, req_ready[s]);
            end
        end
    endtask

    // Give the region used by every later test known contents
    task automatic test_init_region;
        logic [31:0] od, ed;
        logic        oe, ee;
        int          lat;
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16; w++) begin
                run_txn(s, 1'b1, 2'b00, 1'b0, 12'(w * 4), $urandom, 0, od, oe, lat, ed, ee);
                checks++;
                if (oe !== 1'b0 || od !== 32'h0 || lat != wait_of(s) + 1) begin
                    errors++;
                    $display("FAIL init_store inst%0d word%0d got err=%b rdata=%h lat=%0d expected 0/0/%0d",
                             s, w, oe, od, lat, wait_of(s) + 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] old_word, od, ed;
        logic        oe, ee;
        int          lat;
        old_word = {bm[1][19], bm[1][18], bm[1][17], bm[1][16]};
        @(negedge clk);
        req_we[1]    = 1'b1;
        req_bhw[1]   = 2'b00;
        req_sgn[1]   = 1'b0;
        req_addr[1]  = 12'h010;
        req_wdata[1] = ~old_word;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait_outputs got valid=%b ready=%b expected 0/0",
                     rsp_valid[1], req_ready[1]);
        end
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait_release got ready=%b valid=%b expected 1/0",
                     req_ready[1], rsp_valid[1]);
        end
        run_txn(1, 1'b0, 2'b00, 1'b0, 12'h010, 32'h0, 0, od, oe, lat, ed, ee);
        checks++;
        if (od !== old_word || oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait_mem got %h err=%b expected %h err=0", od, oe, old_word);
        end
    endtask

    task automatic test_word;
        logic [31:0] od, ed;
        logic        oe, ee;
        int          lat;
        for (int s = 0; s < 2; s++) begin
            run_txn(s, 1'b1, 2'b00, 1'b0, 12'h020, 32'hDEADBEEF, 0, od, oe, lat, ed, ee);
            checks++;
            if (od !== 32'h0 || oe !== 1'b0 || lat != wait_of(s) + 1) begin
                errors++;
                $display("FAIL word_store inst%0d got rdata=%h err=%b lat=%0d expected 0/0/%0d",
                         s, od, oe, lat, wait_of(s) + 1);
            end
            run_txn(s, 1'b0, 2'b00, 1'b1, 12'h020, 32'h0, 0, od, oe, lat, ed, ee);
            checks++;
            if (od !== 32'hDEADBEEF || oe !== 1'b0 || lat != wait_of(s) + 1) begin
                errors++;
                $display("FAIL word_load inst%0d got rdata=%h err=%b lat=%0d expected deadbeef/0/%0d",
                         s, od, oe, lat, wait_of(s) + 1);
            end
        end
    endtask

    task automatic test_byte;
        logic [31:0] od, ed;
        logic        oe, ee;
        int          lat;
        for (int s = 0; s < 2; s++) begin
            run_txn(s, 1'b1, 2'b00, 1'b0, 12'h020, 32'h11223344, 0, od, oe, lat, ed, ee);
            run_txn(s, 1'b1, 2'b10, 1'b0, 12'h021, 32'h00000080, 0, od, oe, lat, ed, ee);
            checks++;
            if (oe !== 1'b0) begin
                errors++;
                $display("FAIL byte_store_err inst%0d got %b expected 0", s, oe);
            end
            run_txn(s, 1'b0, 2'b00, 1'b0, 12'h020, 32'h0, 0, od, oe, lat, ed, ee);
            checks++;
            if (od !== 32'h11228044) begin
                errors++;
                $display("FAIL byte_merge inst%0d got %h expected 11228044", s, od);
            end
            run_txn(s, 1'b0, 2'b10, 1'b1, 12'h021, 32'h0, 0, od, oe, lat, ed, ee);
            checks++;
            if (od !== 32'hFFFFFF80) begin
                errors++;
                $display("FAIL lb inst%0d got %h expected ffffff80", s, od);
            end
            run_txn(s, 1'b0, 2'b10, 1'b0, 12'h021, 32'h0, 0, od, oe, lat, ed, ee);
            checks++;
            if (od !== 32'h00000080) begin
                errors++;
                $display("FAIL lbu inst%0d got %h expected 00000080", s, od);
            end
        end
    endtask

    task automatic test_half;
        logic [31:0] od, ed;
        logic        oe, ee;
        int          lat;
        for (int s = 0; s < 2; s++) begin
            run_txn(s, 1'b1, 2'b01, 1'b0, 12'h022, 32'h00009ABC, 0, od, oe, lat, ed, ee);
            run_txn(s, 1'b0, 2'b00, 1'b0, 12'h020, 32'h0, 0, od, oe, lat, ed, ee);
            checks++;
            if (od !== 32'h9ABC8044) begin
                errors++;
                $display("FAIL half_merge inst%0d got %h expected 9abc8044", s, od);
            end
            run_txn(s, 1'b0, 2'b01, 1'b1, 12'h022, 32'h0, 0, od, oe, lat, ed, ee);
            checks++;
            if (od !== 32'hFFFF9ABC) begin
                errors++;
                $display("FAIL lh inst%0d got %h expected ffff9abc", s, od);
            end
            run_txn(s, 1'b0, 2'b01, 1'b0, 12'h022, 32'h0, 0, od, oe, lat, ed, ee);
            checks++;
            if (od !== 32'h00009ABC) begin
                errors++;
                $display("FAIL lhu inst%0d got %h expected 00009abc", s, od);
            end
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] od, ed;
        logic        oe, ee;
        int          lat;
        for (int s = 0; s < 2; s++) begin
            run_txn(s, 1'b0, 2'b00, 1'b0, 12'h022, 32'h0, 0, od, oe, lat, ed, ee);
            checks++;
            if (oe !== 1'b1 || od !== 32'h0) begin
                errors++;
                $display("FAIL misaligned_lw inst%0d got err=%b rdata=%h expected 1/0", s, oe, od);
            end
            run_txn(s, 1'b1, 2'b01, 1'b0, 12'h023, 32'h00005555, 0, od, oe, lat, ed, ee);
            checks++;
            if (oe !== 1'b1 || od !== 32'h0) begin
                errors++;
                $display("FAIL misaligned_sh inst%0d got err=%b rdata=%h expected 1/0", s, oe, od);
            end
            run_txn(s, 1'b1, 2'b11, 1'b0, 12'h020, 32'hFFFFFFFF, 0, od, oe, lat, ed, ee);
            checks++;
            if (oe !== 1'b1 || od !== 32'h0) begin
                errors++;
                $display("FAIL reserved_size inst%0d got err=%b rdata=%h expected 1/0", s, oe, od);
            end
            run_txn(s, 1'b0, 2'b00, 1'b0, 12'h020, 32'h0, 0, od, oe, lat, ed, ee);
            checks++;
            if (od !== 32'h9ABC8044 || oe !== 1'b0) begin
                errors++;
                $display("FAIL error_no_write inst%0d got %h err=%b expected 9abc8044 err=0", s, od, oe);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] e1, e2, held;
        logic        ee;
        int          n;
        model_op(1, 1'b0, 2'b00, 1'b0, 12'h020, 32'h0, e1, ee);
        @(negedge clk);
        req_we[1] = 1'b0; req_bhw[1] = 2'b00; req_sgn[1] = 1'b0;
        req_addr[1] = 12'h020; req_wdata[1] = 32'h0; req_valid[1] = 1'b1;
        rsp_ready[1] = 1'b0;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        n = 0;
        @(negedge clk);
        while (rsp_valid[1] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        held = rsp_rdata[1];
        // Offer a second request while the first response is still pending
        req_addr[1]  = 12'h024;
        req_valid[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== e1 || req_ready[1] !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cycle%0d got valid=%b rdata=%h ready=%b expected 1/%h/0",
                         c, rsp_valid[1], rsp_rdata[1], req_ready[1], e1);
            end
            @(negedge clk);
        end
        checks++;
        if (rsp_rdata[1] !== held) begin
            errors++;
            $display("FAIL backpressure_stable got %h expected %h", rsp_rdata[1], held);
        end
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_exit got valid=%b ready=%b expected 0/1",
                     rsp_valid[1], req_ready[1]);
        end
        model_op(1, 1'b0, 2'b00, 1'b0, 12'h024, 32'h0, e2, ee);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        n = 0;
        @(negedge clk);
        while (rsp_valid[1] !== 1'b1 && n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        $display("txn inst1 backpressure follow-up addr=024 -> rdata=%08h lat=%0d", rsp_rdata[1], n);
        checks++;
        if (rsp_rdata[1] !== e2 || n != 4) begin
            errors++;
            $display("FAIL backpressure_next got rdata=%h lat=%0d expected %h/4", rsp_rdata[1], n, e2);
        end
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[1] = 1'b0;
    endtask

    task automatic test_random;
        logic [31:0] od, ed;
        logic        oe, ee;
        logic [1:0]  bhw;
        logic [11:0] addr;
        int          lat;
        for (int s = 0; s < 2; s++) begin
            for (int t = 0; t < 40; t++) begin
                bhw  = 2'($urandom_range(0, 3));
                addr = 12'($urandom_range(0, 63));
                // Mostly aligned traffic, with some deliberately misaligned
                if ($urandom_range(0, 3) != 0) begin
                    if (bhw == 2'b00) addr[1:0] = 2'b00;
                    if (bhw == 2'b01) addr[0]   = 1'b0;
                end
                run_txn(s, 1'($urandom_range(0, 1)), bhw, 1'($urandom_range(0, 1)), addr,
                        $urandom, $urandom_range(0, 2), od, oe, lat, ed, ee);
                checks++;
                if (od !== ed || oe !== ee || lat != wait_of(s) + 1) begin
                    errors++;
                    $display("FAIL random inst%0d txn%0d got rdata=%h err=%b lat=%0d expected %h/%b/%0d",
                             s, t, od, oe, lat, ed, ee, wait_of(s) + 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_init_region();
        test_reset_mid_wait();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_backpressure();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
